// File: rtl/mul_div_core.sv
// -----------------------------------------------------------------------------
// mul_div_core
//
// Multi-cycle 32-bit multiply/divide engine for the P8 MIPS E-stage HI/LO
// wrapper. A request is accepted through a valid/ready handshake. The result
// appears through a second valid/ready handshake after a fixed latency:
// MUL_LAT cycles for multiply and DIV_LAT cycles for divide. The engine holds
// no architectural HI/LO state.
//
// The arithmetic is behavioural and combinational on the captured operands.
// It is registered into out_res0/out_res1 on the cycle the latency counter
// expires. Both MUL_LAT and DIV_LAT must be at least 2.
//
// Parameters:
//   MUL_LAT    cycles from acceptance to out_valid for multiply (default 5)
//   DIV_LAT    cycles from acceptance to out_valid for divide   (default 10)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   in_src0    operand A (multiplicand / dividend)
//   in_src1    operand B (multiplier / divisor)
//   in_op      2'b01 = MUL, 2'b10 = DIV, 2'b00 / 2'b11 = idle (ignored)
//   in_sign    1 = unsigned (multu/divu), 0 = signed (mult/div)
//   in_valid   request strobe
//   out_ready  consumer can take the result
//   in_ready   engine is idle and can accept a request
//   out_valid  result is presented on out_res0/out_res1
//   out_res0   LO word: product[31:0] or quotient
//   out_res1   HI word: product[63:32] or remainder
// -----------------------------------------------------------------------------
module mul_div_core #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_src0,
  input  logic [31:0] in_src1,
  input  logic [1:0]  in_op,
  input  logic        in_sign,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_res0,
  output logic [31:0] out_res1
);

  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------

  // 64-bit product. Each operand is widened to 33 bits: it is sign-extended in
  // signed mode and zero-extended in unsigned mode. One signed multiplier then
  // covers both mult and multu.
  function automatic logic [63:0] mul_fn(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        is_unsigned
  );
    logic signed [32:0] a_ext;
    logic signed [32:0] b_ext;
    logic signed [65:0] prod;
    a_ext = $signed({a[31] & ~is_unsigned, a});
    b_ext = $signed({b[31] & ~is_unsigned, b});
    prod  = a_ext * b_ext;
    return prod[63:0];
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes. The
  // quotient is negated when the operand signs differ, so it truncates toward
  // zero. The remainder takes the sign of the dividend.
  // The 0x80000000 / -1 overflow case needs no special handling: the quotient
  // magnitude is 0x80000000 with a positive sign, which is the required value.
  function automatic logic [63:0] div_fn(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        is_unsigned
  );
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    neg_a = a[31] & ~is_unsigned;
    neg_b = b[31] & ~is_unsigned;
    mag_a = neg_a ? (32'd0 - a) : a;
    mag_b = neg_b ? (32'd0 - b) : b;
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (b == 32'd0) begin
      // Divide by zero: all-ones quotient, dividend passed through, no trap.
      quo = 32'hFFFF_FFFF;
      rem = a;
    end else begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
      quo   = (neg_a ^ neg_b) ? (32'd0 - q_mag) : q_mag;
      rem   = neg_a ? (32'd0 - r_mag) : r_mag;
    end
    return {rem, quo};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      src0_r;
  logic [31:0]      src1_r;
  logic [1:0]       op_r;
  logic             sign_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [31:0]      res0_r;
  logic [31:0]      res1_r;

  logic             is_req_op_s;
  logic             accept_s;
  logic [63:0]      result_s;

  // A request is taken only for MUL or DIV while the engine is idle.
  always_comb begin
    is_req_op_s = 1'b0;
    case (in_op)
      OP_MUL:  is_req_op_s = 1'b1;
      OP_DIV:  is_req_op_s = 1'b1;
      default: is_req_op_s = 1'b0;
    endcase
    accept_s = in_valid & in_ready_r & is_req_op_s;
  end

  // Result of the captured operation. It is only consumed when the counter expires.
  always_comb begin
    result_s = 64'd0;
    case (op_r)
      OP_MUL:  result_s = mul_fn(src0_r, src1_r, sign_r);
      OP_DIV:  result_s = div_fn(src0_r, src1_r, sign_r);
      default: result_s = 64'd0;
    endcase
  end

  // Control FSM with operand capture, latency counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      src0_r      <= 32'd0;
      src1_r      <= 32'd0;
      op_r        <= 2'b00;
      sign_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      res0_r      <= 32'd0;
      res1_r      <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            src0_r     <= in_src0;
            src1_r     <= in_src1;
            op_r       <= in_op;
            sign_r     <= in_sign;
            cnt_r      <= (in_op == OP_DIV) ? DIV_LOAD : MUL_LOAD;
            in_ready_r <= 1'b0;
            state_r    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // The final decrement, 1 -> 0, happens together with the result
          // write. BUSY therefore lasts LAT-1 cycles, and out_valid rises
          // exactly LAT cycles after acceptance.
          if (cnt_r <= CNT_ONE) begin
            cnt_r       <= CNT_ZERO;
            res0_r      <= result_s[31:0];
            res1_r      <= result_s[63:32];
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_DONE: begin
          // The result registers keep their value after the handshake.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_res0  = res0_r;
  assign out_res1  = res1_r;

endmodule
